// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit between the ALU and data memory
//
// Purpose:
//   Accepts one LW/SW op at a time from the execute stage. It runs a registered
//   req/ack access to data memory and returns load data to register writeback.
//   busy_o stalls upstream stages while an op is in flight. If MAX_WAIT > 0,
//   an access that sees no ack for MAX_WAIT cycles is abandoned and err_o pulses.
//
// Optional feature (macro LSU_MISALIGN_CHECK_EN):
//   When defined, an accepted op whose address has req_addr_i[1:0] != 0 is not
//   issued to memory. err_o pulses instead and the unit stays idle.
//   When undefined, the address is forwarded unchanged.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_i / req_ready_o      op handshake from execute stage
//   req_we_i, req_addr_i,
//   req_wdata_i, req_rd_i          op fields: 0=LW / 1=SW, address, store data, load dest
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o        memory request, held until ack or timeout
//   mem_ack_i, mem_rdata_i         memory completion and read data
//   wb_valid_o, wb_rd_o, wb_data_o writeback pulse for loads to a non-x0 register
//   done_o                         op-complete pulse
//   busy_o                         inverse of req_ready_o
//   err_o                          timeout / misalignment pulse

module riscv_lsu #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Counter is kept at least 1 bit wide so MAX_WAIT=0 (no timeout) still elaborates.
  localparam int              CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [4:0]        rd_q,        rd_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q,      busy_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q,  wb_valid_d;
  logic [4:0]        wb_rd_q,     wb_rd_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              misaligned;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = (req_addr_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (misaligned) begin
            // Rejected without touching memory; remain ready for the next op.
            err_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            rd_d        = req_rd_i;
            req_ready_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we_i;
            mem_addr_d  = req_addr_i;
            mem_wdata_d = req_wdata_i;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is checked before timeout so an ack in the last allowed cycle succeeds.
        if (mem_ack_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) begin
            wb_data_d = mem_rdata_i;
            if (rd_q != 5'd0) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd_q;
            end
          end
        end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          err_d       = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
      end
    endcase

    busy_d = ~req_ready_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
